// File: rtl/task_frame_pkg.sv
// Shared constants and types for the task frame receiver and the CRC32 helper.
// The payload is a packed byte buffer; each field sits at a fixed byte offset.
package task_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam int PAYLOAD_LEN = 155;
  localparam int CRC_LEN     = 4;

  localparam int D1_OFS     = 0;
  localparam int D1_LEN     = 1;
  localparam int D2_OFS     = 1;
  localparam int D2_LEN     = 1;
  localparam int OP_OFS     = 2;
  localparam int OP_LEN     = 4;
  localparam int FLAGS_OFS  = 6;
  localparam int FLAGS_LEN  = 1;
  localparam int EXPIRE_OFS = 7;
  localparam int EXPIRE_LEN = 4;
  localparam int MYADDR_OFS = 11;
  localparam int MYADDR_LEN = 32;
  localparam int RDATA1_OFS = 43;
  localparam int RDATA1_LEN = 32;
  localparam int PSEED_OFS  = 75;
  localparam int PSEED_LEN  = 16;
  localparam int RDATA2_OFS = 91;
  localparam int RDATA2_LEN = 32;
  localparam int TARGET_OFS = 123;
  localparam int TARGET_LEN = 32;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC_RX,
    CHECK
  } state_e;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected CRC32 (poly 0xEDB88320), purely combinational.
// Shared by the task receiver and the result transmitter.
module crc32_byte
  import task_frame_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i ^ {24'h0, byte_i};
    for (int b = 0; b < 8; b++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/task_frame_rx.sv
// Parses SOF + 155 payload bytes + CRC32 into a shadow buffer and commits it
// to the task outputs only when the trailing CRC matches.
module task_frame_rx
  import task_frame_pkg::*;
#(
  parameter logic [7:0] SOF         = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = 5_000_000,
  parameter int         TMR_W       = 23
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_byte,
  input  logic         i_byte_valid,
  output logic [7:0]   o_d1,
  output logic [7:0]   o_d2,
  output logic [31:0]  o_op,
  output logic [7:0]   o_flags,
  output logic [31:0]  o_expire,
  output logic [255:0] o_myaddr,
  output logic [255:0] o_rdata_1,
  output logic [127:0] o_pseed,
  output logic [255:0] o_rdata_2,
  output logic [255:0] o_target,
  output logic         o_task_valid,
  output logic         o_crc_err,
  output logic         o_timeout,
  output logic         o_busy
);

  localparam int PAY_W = PAYLOAD_LEN * 8;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q;
  logic [31:0]        crc_q, crcNext, rxCrc_q;
  logic [PAY_W-1:0]   shadow_q, task_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               taskValid_q, crcErr_q, timeout_q;
  logic               lastPayload, lastCrc, tmrExpired, crcGood;
  logic               commit, reject, abort;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .byte_i (i_byte),
    .crc_o  (crcNext)
  );

  assign lastPayload = (cnt_q == 8'(PAYLOAD_LEN - 1));
  assign lastCrc     = (cnt_q == 8'(CRC_LEN - 1));
  // An arriving byte beats an expiring timer in the same cycle.
  assign tmrExpired  = (tmr_q == TMR_W'(TIMEOUT_CYC)) && !i_byte_valid;
  assign crcGood     = ((crc_q ^ 32'hFFFFFFFF) == rxCrc_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_byte_valid && i_byte == SOF) state_d = PAYLOAD;
      PAYLOAD: if (i_byte_valid && lastPayload)   state_d = CRC_RX;
               else if (tmrExpired)             state_d = IDLE;
      CRC_RX:  if (i_byte_valid && lastCrc)       state_d = CHECK;
               else if (tmrExpired)             state_d = IDLE;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    commit = 1'b0;
    reject = 1'b0;
    abort  = 1'b0;
    if (state_q == CHECK) begin
      commit = crcGood;
      reject = !crcGood;
    end
    if ((state_q == PAYLOAD || state_q == CRC_RX) && tmrExpired) abort = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q       <= '0;
      crc_q       <= '0;
      rxCrc_q     <= '0;
      shadow_q    <= '0;
      task_q      <= '0;
      tmr_q       <= '0;
      taskValid_q <= 1'b0;
      crcErr_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      taskValid_q <= commit;
      crcErr_q    <= reject;
      timeout_q   <= abort;
      if (i_byte_valid || state_d == IDLE) tmr_q <= '0;
      else                                 tmr_q <= tmr_q + TMR_W'(1);
      if (commit) task_q <= shadow_q;
      // Received CRC shifts in from the top so the first (LSB) byte ends at [7:0].
      if (i_byte_valid) begin
        unique case (state_q)
          IDLE: if (i_byte == SOF) begin
            cnt_q <= '0;
            crc_q <= CRC32_INIT;
          end
          PAYLOAD: begin
            shadow_q[{cnt_q, 3'b000} +: 8] <= i_byte;
            crc_q <= crcNext;
            cnt_q <= lastPayload ? 8'd0 : cnt_q + 8'd1;
          end
          CRC_RX: begin
            rxCrc_q <= {i_byte, rxCrc_q[31:8]};
            cnt_q   <= cnt_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_d1         = task_q[D1_OFS*8     +: D1_LEN*8];
  assign o_d2         = task_q[D2_OFS*8     +: D2_LEN*8];
  assign o_op         = task_q[OP_OFS*8     +: OP_LEN*8];
  assign o_flags      = task_q[FLAGS_OFS*8  +: FLAGS_LEN*8];
  assign o_expire     = task_q[EXPIRE_OFS*8 +: EXPIRE_LEN*8];
  assign o_myaddr     = task_q[MYADDR_OFS*8 +: MYADDR_LEN*8];
  assign o_rdata_1    = task_q[RDATA1_OFS*8 +: RDATA1_LEN*8];
  assign o_pseed      = task_q[PSEED_OFS*8  +: PSEED_LEN*8];
  assign o_rdata_2    = task_q[RDATA2_OFS*8 +: RDATA2_LEN*8];
  assign o_target     = task_q[TARGET_OFS*8 +: TARGET_LEN*8];
  assign o_task_valid = taskValid_q;
  assign o_crc_err    = crcErr_q;
  assign o_timeout    = timeout_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_task_frame_rx.sv
// Scoreboard bench for task_frame_rx: stimulus pushes expected events, a
// negedge monitor pops and compares them when a pulse output fires.
module tb_task_frame_rx;
  import task_frame_pkg::*;

  localparam int TO_CYC = 100;
  localparam int EV_TASK = 1, EV_CRCERR = 2, EV_TIMEOUT = 3;

  typedef struct {
    int                         kind;
    int                         minCyc;
    int                         maxCyc;
    logic [PAYLOAD_LEN*8-1:0]   payFlat;
  } expItem_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   byteIn = '0;
  logic         byteValid = 1'b0;
  logic [7:0]   oD1, oD2, oFlags;
  logic [31:0]  oOp, oExpire;
  logic [255:0] oMyaddr, oRdata1, oRdata2, oTarget;
  logic [127:0] oPseed;
  logic         oTaskValid, oCrcErr, oTimeout, oBusy;

  logic [31:0]  tCrcIn = '0, tCrcOut;
  logic [7:0]   tByte = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastSample = 0;
  expItem_t expQ[$];
  logic [7:0] pay [PAYLOAD_LEN];

  task_frame_rx #(.SOF(8'hA5), .TIMEOUT_CYC(TO_CYC), .TMR_W(23)) dut (
    .i_clk(clk), .i_reset(rst), .i_byte(byteIn), .i_byte_valid(byteValid),
    .o_d1(oD1), .o_d2(oD2), .o_op(oOp), .o_flags(oFlags), .o_expire(oExpire),
    .o_myaddr(oMyaddr), .o_rdata_1(oRdata1), .o_pseed(oPseed),
    .o_rdata_2(oRdata2), .o_target(oTarget), .o_task_valid(oTaskValid),
    .o_crc_err(oCrcErr), .o_timeout(oTimeout), .o_busy(oBusy)
  );

  crc32_byte uCrc (.crc_i(tCrcIn), .byte_i(tByte), .crc_o(tCrcOut));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [PAYLOAD_LEN*8-1:0] payFlat();
    logic [PAYLOAD_LEN*8-1:0] f;
    f = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++) f[i*8 +: 8] = pay[i];
    return f;
  endfunction

  // Bit-serial reference: feed one data bit at a time into the LFSR.
  function automatic logic [31:0] crcOfPay();
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < PAYLOAD_LEN; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay[i][b];
        c = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    return ~c;
  endfunction

  task automatic loadDefaultTask();
    for (int i = 0; i < PAYLOAD_LEN; i++) pay[i] = 8'h00;
    pay[0] = 8'h11; pay[1] = 8'h22;
    pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55; pay[5] = 8'h66;
    pay[6] = 8'h77;
    pay[7] = 8'h88; pay[8] = 8'h99; pay[9] = 8'hAA; pay[10] = 8'hBB;
    for (int i = 0; i < 32; i++) pay[11 + i] = 8'(i);
    for (int i = 0; i < 32; i++) pay[43 + i] = 8'(8'h40 + i);
    for (int i = 0; i < 16; i++) pay[75 + i] = 8'(8'h80 + i);
    for (int i = 0; i < 32; i++) pay[91 + i] = 8'(8'hC0 ^ i);
    pay[123] = 8'h00;
    for (int i = 1; i < 32; i++) pay[123 + i] = 8'hFF;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    byteIn = b;
    byteValid = 1'b1;
    @(posedge clk); #1;
    byteValid = 1'b0;
    lastSample = cyc;
  endtask

  task automatic sendFrame(input bit corrupt);
    logic [31:0] c;
    expItem_t it;
    c = crcOfPay();
    if (corrupt) c[31:24] = c[31:24] ^ 8'h01;
    applyStimulus(8'hA5);
    for (int i = 0; i < PAYLOAD_LEN; i++) applyStimulus(pay[i]);
    for (int i = 0; i < CRC_LEN; i++) applyStimulus(c[i*8 +: 8]);
    it.kind = corrupt ? EV_CRCERR : EV_TASK;
    it.minCyc = lastSample + 1;
    it.maxCyc = lastSample + 1;
    it.payFlat = payFlat();
    expQ.push_back(it);
  endtask

  task automatic drainQueue(input string name);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(posedge clk);
    checkOutput(name, 256'(expQ.size()), 256'(0));
    @(negedge clk);
  endtask

  int kindAct;
  expItem_t mItem;
  always @(negedge clk) begin
    if (!rst && (oTaskValid || oCrcErr || oTimeout)) begin
      kindAct = oTaskValid ? EV_TASK : (oCrcErr ? EV_CRCERR : EV_TIMEOUT);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedEvent actual kind=%0d required none", kindAct);
      end else begin
        mItem = expQ.pop_front();
        checkOutput("eventKind", 256'(kindAct), 256'(mItem.kind));
        checks++;
        if (cyc < mItem.minCyc || cyc > mItem.maxCyc) begin
          errors++;
          $display("[TB] FAIL eventCycle actual=%0d required=%0d..%0d",
                   cyc, mItem.minCyc, mItem.maxCyc);
        end
        if (mItem.kind == EV_TASK) begin
          checkOutput("d1", 256'(oD1), 256'(mItem.payFlat[D1_OFS*8 +: 8]));
          checkOutput("d2", 256'(oD2), 256'(mItem.payFlat[D2_OFS*8 +: 8]));
          checkOutput("op", 256'(oOp), 256'(mItem.payFlat[OP_OFS*8 +: 32]));
          checkOutput("flags", 256'(oFlags), 256'(mItem.payFlat[FLAGS_OFS*8 +: 8]));
          checkOutput("expire", 256'(oExpire), 256'(mItem.payFlat[EXPIRE_OFS*8 +: 32]));
          checkOutput("myaddr", oMyaddr, mItem.payFlat[MYADDR_OFS*8 +: 256]);
          checkOutput("rdata1", oRdata1, mItem.payFlat[RDATA1_OFS*8 +: 256]);
          checkOutput("pseed", 256'(oPseed), 256'(mItem.payFlat[PSEED_OFS*8 +: 128]));
          checkOutput("rdata2", oRdata2, mItem.payFlat[RDATA2_OFS*8 +: 256]);
          checkOutput("target", oTarget, mItem.payFlat[TARGET_OFS*8 +: 256]);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] c;
    string s;
    expItem_t it;

    c = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      tCrcIn = c; tByte = 8'h00; #1; c = tCrcOut;
    end
    checkOutput("crcUnitZeros", 256'(c ^ 32'hFFFFFFFF), 256'(32'h2144DF1C));
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) begin
      tCrcIn = c; tByte = s[i]; #1; c = tCrcOut;
    end
    checkOutput("crcUnitAscii", 256'(c ^ 32'hFFFFFFFF), 256'(32'hCBF43926));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetD1", 256'(oD1), 256'(0));
    checkOutput("resetTarget", oTarget, 256'(0));
    checkOutput("resetBusy", 256'(oBusy), 256'(0));

    // Noise in IDLE must not start a frame
    applyStimulus(8'h00); checkOutput("noiseBusy0", 256'(oBusy), 256'(0));
    applyStimulus(8'hFF); checkOutput("noiseBusy1", 256'(oBusy), 256'(0));
    applyStimulus(8'h13); checkOutput("noiseBusy2", 256'(oBusy), 256'(0));

    loadDefaultTask();
    sendFrame(1'b0);
    drainQueue("goodFrameDrain");
    checkOutput("goodTargetLo", 256'(oTarget[7:0]), 256'(8'h00));
    checkOutput("goodTargetHi", 256'(oTarget[255:248]), 256'(8'hFF));
    checkOutput("goodOp", 256'(oOp), 256'(32'h66554433));
    checkOutput("goodBusyAfter", 256'(oBusy), 256'(0));

    sendFrame(1'b1);
    drainQueue("crcErrDrain");
    checkOutput("holdD1", 256'(oD1), 256'(8'h11));
    checkOutput("holdOp", 256'(oOp), 256'(32'h66554433));

    pay[0] = 8'h5A;
    sendFrame(1'b0);
    drainQueue("afterErrDrain");
    checkOutput("newD1", 256'(oD1), 256'(8'h5A));

    applyStimulus(8'hA5);
    checkOutput("busyInFrame", 256'(oBusy), 256'(1));
    for (int i = 0; i < 10; i++) applyStimulus(8'(i + 1));
    it.kind = EV_TIMEOUT;
    it.minCyc = lastSample + TO_CYC;
    it.maxCyc = lastSample + TO_CYC + 2;
    it.payFlat = '0;
    expQ.push_back(it);
    drainQueue("timeoutDrain");
    checkOutput("busyAfterTimeout", 256'(oBusy), 256'(0));
    checkOutput("timeoutHoldD1", 256'(oD1), 256'(8'h5A));

    loadDefaultTask();
    sendFrame(1'b0);
    drainQueue("afterTimeoutDrain");

    pay[0] = 8'hA5;
    pay[154] = 8'hA5;
    sendFrame(1'b0);
    drainQueue("embeddedSofDrain");
    checkOutput("embeddedD1", 256'(oD1), 256'(8'hA5));
    checkOutput("embeddedTargetHi", 256'(oTarget[255:248]), 256'(8'hA5));

    applyStimulus(8'hA5);
    for (int i = 0; i < 80; i++) applyStimulus(pay[i]);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midResetD1", 256'(oD1), 256'(0));
    checkOutput("midResetOp", 256'(oOp), 256'(0));
    checkOutput("midResetTarget", oTarget, 256'(0));
    checkOutput("midResetBusy", 256'(oBusy), 256'(0));
    checkOutput("midResetPulses", 256'({oTaskValid, oCrcErr, oTimeout}), 256'(0));

    loadDefaultTask();
    sendFrame(1'b0);
    drainQueue("afterResetDrain");
    checkOutput("afterResetD2", 256'(oD2), 256'(8'h22));

    repeat (20) @(posedge clk);
    $display("[TB] stimulus complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
